// File: rtl/isa_defs.sv
// Shared ISA definitions for the multi-cycle datapath: opcodes, FSM state
// encodings, instruction field positions and small decode helpers.
package isa_defs;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;
  localparam logic [3:0] OP_LI   = 4'hD;
  localparam logic [3:0] OP_BEQ  = 4'hE;
  localparam logic [3:0] OP_BNE  = 4'hF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int SH_MSB  = 2;
  localparam int IMM_MSB = 5;
  localparam int OFF_MSB = 8;

  // Control-flow instructions finish in EXEC and never write a register.
  function automatic logic is_flow_op(input logic [3:0] op);
    return (op == OP_J) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the multi-cycle datapath. Address and branch ops reuse
// the adder/subtractor; zero flags an equal compare for BEQ/BNE.
module alu_core
  import isa_defs::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sh,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Result select by opcode
  always_comb begin
    result = {DATA_W{1'b0}};
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
      OP_SUB, OP_BEQ, OP_BNE:        result = a - b;
      OP_AND:                        result = a & b;
      OP_OR:                         result = a | b;
      OP_XOR:                        result = a ^ b;
      OP_NOR:                        result = ~(a | b);
      OP_SLT:                        result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:                        result = a << sh;
      OP_SRL:                        result = a >> sh;
      OP_LI:                         result = b;
      default:                       result = {DATA_W{1'b0}};
    endcase
  end

  assign zero = (result == {DATA_W{1'b0}});

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-ISA core: FETCH/DECODE/EXEC/MEM/WB sequencing, loadable
// IMEM/DMEM, 8-entry register file. Optional DATAPATH_TRACE_EN adds retire ports.
module multicycle_datapath
  import isa_defs::*;
#(
  parameter int  DATA_W     = 16,
  parameter int  IMEM_DEPTH = 16,
  parameter int  DMEM_DEPTH = 8,
  localparam int PC_W       = $clog2(IMEM_DEPTH),
  localparam int DA_W       = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [PC_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted
`ifdef DATAPATH_TRACE_EN
  ,
  output logic              retire_valid,
  output logic [PC_W-1:0]   retire_pc
`endif
);

  logic [2:0]        state_r, state_next_s;
  logic [PC_W-1:0]   pc_r, pc_next_s;
  logic [15:0]       ir_r;
  logic [DATA_W-1:0] a_r, b_r, d_r, alu_out_r, mdr_r;
  logic              busy_r, halted_r;
  logic [DATA_W-1:0] regs_r [0:7];
  logic [15:0]       imem_r [0:IMEM_DEPTH-1];
  logic [DATA_W-1:0] dmem_r [0:DMEM_DEPTH-1];

  logic [3:0]        op_s;
  logic [2:0]        rd_s, rs_s, rt_s, sh_s;
  logic [5:0]        imm6_s;
  logic [8:0]        off9_s;
  logic [31:0]       off_ext_s;
  logic [DATA_W-1:0] simm_s, zimm_s, alu_b_s, alu_result_s, wb_data_s;
  logic              alu_zero_s, idle_s;
  logic [DA_W-1:0]   dmem_addr_s;

  assign op_s      = ir_r[OP_MSB:OP_LSB];
  assign rd_s      = ir_r[RD_MSB:RD_LSB];
  assign rs_s      = ir_r[RS_MSB:RS_LSB];
  assign rt_s      = ir_r[RT_MSB:RT_LSB];
  assign sh_s      = ir_r[SH_MSB:0];
  assign imm6_s    = ir_r[IMM_MSB:0];
  assign off9_s    = ir_r[OFF_MSB:0];
  assign off_ext_s = {{23{off9_s[8]}}, off9_s};
  assign simm_s    = {{(DATA_W-6){imm6_s[5]}}, imm6_s};
  assign zimm_s    = {{(DATA_W-6){1'b0}}, imm6_s};
  assign idle_s    = (state_r == S_IDLE) || (state_r == S_HALT);
  assign dmem_addr_s = alu_out_r[DA_W-1:0];
  assign wb_data_s = (op_s == OP_LW) ? mdr_r : alu_out_r;

  // ALU second operand: immediates for I-type, rd value for branch compare
  always_comb begin
    alu_b_s = b_r;
    case (op_s)
      OP_ADDI, OP_LW, OP_SW: alu_b_s = simm_s;
      OP_LI:                 alu_b_s = zimm_s;
      OP_BEQ, OP_BNE:        alu_b_s = d_r;
      default:               alu_b_s = b_r;
    endcase
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op     (op_s),
    .a      (a_r),
    .b      (alu_b_s),
    .sh     (sh_s),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  // Next PC computed in EXEC; J with off9==0 leaves PC unchanged (halt)
  always_comb begin
    pc_next_s = pc_r + PC_W'(1);
    case (op_s)
      OP_J:   pc_next_s = PC_W'(32'(pc_r) + off_ext_s);
      OP_BEQ: begin
        if (alu_zero_s) pc_next_s = PC_W'(imm6_s);
        else            pc_next_s = pc_r + PC_W'(1);
      end
      OP_BNE: begin
        if (!alu_zero_s) pc_next_s = PC_W'(imm6_s);
        else             pc_next_s = pc_r + PC_W'(1);
      end
      default: pc_next_s = pc_r + PC_W'(1);
    endcase
  end

  // FSM next-state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE, S_HALT: begin
        if (start) state_next_s = S_FETCH;
        else       state_next_s = state_r;
      end
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: state_next_s = S_EXEC;
      S_EXEC: begin
        if ((op_s == OP_J) && (off9_s == 9'd0))     state_next_s = S_HALT;
        else if (is_flow_op(op_s))                  state_next_s = S_FETCH;
        else if ((op_s == OP_LW) || (op_s == OP_SW)) state_next_s = S_MEM;
        else                                        state_next_s = S_WB;
      end
      S_MEM: begin
        if (op_s == OP_LW) state_next_s = S_WB;
        else               state_next_s = S_FETCH;
      end
      S_WB:    state_next_s = S_FETCH;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Sequencer, pipeline latches and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      pc_r      <= {PC_W{1'b0}};
      ir_r      <= 16'h0000;
      a_r       <= {DATA_W{1'b0}};
      b_r       <= {DATA_W{1'b0}};
      d_r       <= {DATA_W{1'b0}};
      alu_out_r <= {DATA_W{1'b0}};
      mdr_r     <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
      halted_r  <= 1'b0;
      for (int i = 0; i < 8; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s != S_IDLE) && (state_next_s != S_HALT);
      halted_r <= (state_next_s == S_HALT);
      case (state_r)
        S_IDLE, S_HALT: if (start) pc_r <= {PC_W{1'b0}};
        S_FETCH:  ir_r <= imem_r[pc_r];
        S_DECODE: begin
          a_r <= regs_r[rs_s];
          b_r <= regs_r[rt_s];
          d_r <= regs_r[rd_s];
        end
        S_EXEC: begin
          alu_out_r <= alu_result_s;
          pc_r      <= pc_next_s;
        end
        S_MEM: mdr_r <= dmem_r[dmem_addr_s];
        S_WB:  if (rd_s != 3'd0) regs_r[rd_s] <= wb_data_s;
        default: ;
      endcase
    end
  end

  // Memories: host load port while stopped, SW store at the end of MEM
  always_ff @(posedge clk) begin
    if (ld_we && idle_s) begin
      if (ld_sel) dmem_r[ld_addr[DA_W-1:0]] <= ld_wdata;
      else        imem_r[ld_addr] <= ld_wdata[15:0];
    end
    if ((state_r == S_MEM) && (op_s == OP_SW)) dmem_r[dmem_addr_s] <= d_r;
  end

  assign dbg_rdata = regs_r[dbg_raddr];
  assign pc        = pc_r;
  assign busy      = busy_r;
  assign halted    = halted_r;

`ifdef DATAPATH_TRACE_EN
  logic [PC_W-1:0] ipc_r, retire_pc_r;
  logic            retire_valid_r, retire_next_s;

  // Raised on the edge that enters an instruction's final state
  assign retire_next_s = ((state_r == S_DECODE) && is_flow_op(op_s)) ||
                         (state_next_s == S_WB) ||
                         ((state_next_s == S_MEM) && (op_s == OP_SW));

  // Retire trace registers; ipc_r holds the fetched instruction's PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ipc_r          <= {PC_W{1'b0}};
      retire_pc_r    <= {PC_W{1'b0}};
      retire_valid_r <= 1'b0;
    end else begin
      if (state_r == S_FETCH) ipc_r <= pc_r;
      retire_valid_r <= retire_next_s;
      if (retire_next_s) retire_pc_r <= ipc_r;
    end
  end

  assign retire_valid = retire_valid_r;
  assign retire_pc    = retire_pc_r;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: directed ISA programs plus
// randomized straight-line programs checked against an instruction-level model.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset, start, ld_we, ld_sel;
  logic [3:0]  ld_addr;
  logic [15:0] ld_wdata;
  logic [2:0]  dbg_raddr;
  logic [15:0] dbg_rdata;
  logic [3:0]  pc;
  logic        busy, halted;
`ifdef DATAPATH_TRACE_EN
  logic        retire_valid;
  logic [3:0]  retire_pc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_imem [16];
  logic [15:0] m_dmem [8];
  logic [15:0] m_reg  [8];
  logic [3:0]  ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                            4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD};

  multicycle_datapath #(.DATA_W(16), .IMEM_DEPTH(16), .DMEM_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_we(ld_we), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .pc(pc), .busy(busy), .halted(halted)
`ifdef DATAPATH_TRACE_EN
    , .retire_valid(retire_valid), .retire_pc(retire_pc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd, rs, rt, sh);
    return {op, rd, rs, rt, sh};
  endfunction
  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd, rs, input logic [5:0] imm);
    return {op, rd, rs, imm};
  endfunction
  function automatic logic [15:0] enc_j(input logic [8:0] off);
    return {4'h9, 3'd0, off};
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; ld_we = 1'b0; ld_sel = 1'b0;
    ld_addr = 4'd0; ld_wdata = 16'd0; dbg_raddr = 3'd0;
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
  endtask

  task automatic load_word(input logic sel, input logic [3:0] addr, input logic [15:0] data);
    ld_sel = sel; ld_addr = addr; ld_wdata = data; ld_we = 1'b1;
    step(1);
    ld_we = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) m_imem[i] = 16'h9000;
  endtask

  task automatic load_imem();
    for (int i = 0; i < 16; i++) load_word(1'b0, 4'(i), m_imem[i]);
  endtask

  task automatic load_dmem();
    for (int i = 0; i < 8; i++) load_word(1'b1, 4'(i), m_dmem[i]);
  endtask

  task automatic go();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < 400) begin step(1); cyc++; end
  endtask

  task automatic rd_reg(input logic [2:0] r, output logic [15:0] v);
    dbg_raddr = r; #1; v = dbg_rdata;
  endtask

  // Instruction-level interpreter: runs from PC 0 until J 0, totals cycles
  task automatic model_run(output int cyc, output logic [3:0] hpc);
    logic [3:0] mpc, npc, op;
    logic [15:0] ins, a, b, d, simm, w;
    logic [2:0] rd, rs, rt, sh;
    logic [5:0] imm;
    logic [8:0] off;
    bit done, wr;
    mpc = 4'd0; cyc = 0; done = 0;
    for (int s = 0; s < 100 && !done; s++) begin
      ins = m_imem[mpc];
      op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
      sh = ins[2:0]; imm = ins[5:0]; off = ins[8:0];
      a = m_reg[rs]; b = m_reg[rt]; d = m_reg[rd];
      simm = {{10{imm[5]}}, imm};
      npc = mpc + 4'd1; wr = 1; w = 16'd0;
      case (op)
        4'h7:             cyc += 5;
        4'h9, 4'hE, 4'hF: cyc += 3;
        default:          cyc += 4;
      endcase
      case (op)
        4'h0: w = a + b;
        4'h1: w = a - b;
        4'h2: w = a & b;
        4'h3: w = a | b;
        4'h4: w = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        4'h5: w = a << sh;
        4'h6: w = a + simm;
        4'h7: w = m_dmem[3'(a + simm)];
        4'h8: begin m_dmem[3'(a + simm)] = d; wr = 0; end
        4'h9: begin
          wr = 0;
          if (off == 9'd0) begin done = 1; npc = mpc; end
          else npc = 4'(int'(mpc) + int'($signed(off)));
        end
        4'hA: w = a >> sh;
        4'hB: w = a ^ b;
        4'hC: w = ~(a | b);
        4'hD: w = {10'd0, imm};
        4'hE: begin wr = 0; if (a == d) npc = 4'(imm); end
        default: begin wr = 0; if (a != d) npc = 4'(imm); end
      endcase
      if (wr && rd != 3'd0) m_reg[rd] = w;
      mpc = npc;
    end
    hpc = mpc;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    for (int r = 0; r < 8; r++) begin
      rd_reg(3'(r), v);
      n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL reset_R%0d: got %h expected 0000", r, v); end
    end
`ifdef DATAPATH_TRACE_EN
    n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %b expected 0", retire_valid); end
`endif
  endtask

  task automatic test_alu_program();
    int cyc;
    logic [15:0] v;
    do_reset(); clear_prog();
    m_imem[0] = enc_i(4'hD, 3'd1, 3'd0, 6'd5);
    m_imem[1] = enc_i(4'hD, 3'd2, 3'd0, 6'd3);
    m_imem[2] = enc_r(4'h1, 3'd3, 3'd1, 3'd2, 3'd0);
    m_imem[3] = enc_r(4'h5, 3'd4, 3'd1, 3'd0, 3'd2);
    load_imem(); go();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL alu_busy: got %b expected 1", busy); end
    wait_halt(cyc);
    n_checks++; if (cyc !== 19) begin n_fail++; $display("FAIL alu_cycles: got %0d expected 19", cyc); end
    n_checks++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL alu_halted: got halted=%b busy=%b expected 1/0", halted, busy); end
    n_checks++; if (pc !== 4'd4) begin n_fail++; $display("FAIL alu_pc: got %0d expected 4", pc); end
    rd_reg(3'd3, v);
    n_checks++; if (v !== 16'd2) begin n_fail++; $display("FAIL alu_R3: got %h expected 0002", v); end
    rd_reg(3'd4, v);
    n_checks++; if (v !== 16'd20) begin n_fail++; $display("FAIL alu_R4: got %h expected 0014", v); end
  endtask

  task automatic test_memory();
    int cyc;
    logic [15:0] v;
    do_reset(); clear_prog();
    for (int i = 0; i < 8; i++) m_dmem[i] = 16'h0100 + 16'(i);
    m_dmem[2] = 16'd7; m_dmem[3] = 16'hBEEF;
    load_dmem();
    m_imem[0] = enc_i(4'hD, 3'd1, 3'd0, 6'd1);
    m_imem[1] = enc_i(4'h7, 3'd5, 3'd1, 6'd1);
    m_imem[2] = enc_i(4'h8, 3'd5, 3'd0, 6'd3);
    m_imem[3] = enc_i(4'h7, 3'd6, 3'd0, 6'd3);
    load_imem(); go(); wait_halt(cyc);
    n_checks++; if (cyc !== 21) begin n_fail++; $display("FAIL mem_cycles: got %0d expected 21", cyc); end
    rd_reg(3'd5, v);
    n_checks++; if (v !== 16'd7) begin n_fail++; $display("FAIL mem_R5: got %h expected 0007", v); end
    rd_reg(3'd6, v);
    n_checks++; if (v !== 16'd7) begin n_fail++; $display("FAIL mem_dmem3: got %h expected 0007", v); end
  endtask

  task automatic test_branch();
    int cyc;
    do_reset(); clear_prog();
    m_imem[0] = enc_i(4'hD, 3'd1, 3'd0, 6'd4);
    m_imem[1] = enc_i(4'hD, 3'd2, 3'd0, 6'd4);
    m_imem[2] = enc_i(4'hE, 3'd2, 3'd1, 6'd6);
    m_imem[6] = enc_i(4'hF, 3'd2, 3'd1, 6'd12);
    load_imem(); go();
    step(8);
    n_checks++; if (pc !== 4'd2) begin n_fail++; $display("FAIL br_pre_pc: got %0d expected 2", pc); end
    step(3);
    n_checks++; if (pc !== 4'd6) begin n_fail++; $display("FAIL beq_taken_pc: got %0d expected 6", pc); end
    step(3);
    n_checks++; if (pc !== 4'd7) begin n_fail++; $display("FAIL bne_fall_pc: got %0d expected 7", pc); end
    wait_halt(cyc);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL br_halt_cycles: got %0d expected 3", cyc); end
  endtask

  task automatic test_r0_wrap();
    int cyc;
    logic [15:0] v;
    do_reset(); clear_prog();
    m_imem[0]  = enc_i(4'h6, 3'd0, 3'd0, 6'd5);
    m_imem[1]  = enc_j(9'h1FD);
    m_imem[14] = enc_i(4'h6, 3'd1, 3'd0, 6'h3F);
    load_imem(); go();
    step(7);
    n_checks++; if (pc !== 4'd14) begin n_fail++; $display("FAIL jump_wrap_pc: got %0d expected 14", pc); end
    wait_halt(cyc);
    n_checks++; if (cyc !== 7 || pc !== 4'd15) begin n_fail++; $display("FAIL wrap_halt: got cyc=%0d pc=%0d expected 7/15", cyc, pc); end
    rd_reg(3'd0, v);
    n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL r0_discard: got %h expected 0000", v); end
    rd_reg(3'd1, v);
    n_checks++; if (v !== 16'hFFFF) begin n_fail++; $display("FAIL addi_neg: got %h expected ffff", v); end
  endtask

  task automatic test_start_with_load();
    int cyc;
    logic [15:0] v;
    do_reset(); clear_prog();
    m_imem[0] = enc_i(4'hD, 3'd1, 3'd0, 6'd1);
    load_imem();
    ld_sel = 1'b0; ld_addr = 4'd0; ld_wdata = enc_i(4'hD, 3'd2, 3'd0, 6'd7);
    ld_we = 1'b1; start = 1'b1;
    step(1);
    ld_we = 1'b0; start = 1'b0;
    wait_halt(cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL startld_cycles: got %0d expected 7", cyc); end
    rd_reg(3'd2, v);
    n_checks++; if (v !== 16'd7) begin n_fail++; $display("FAIL startld_R2: got %h expected 0007", v); end
    rd_reg(3'd1, v);
    n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL startld_R1: got %h expected 0000", v); end
  endtask

  task automatic test_busy_ignores();
    int cyc;
    logic [15:0] v;
    do_reset(); clear_prog();
    m_imem[0] = enc_i(4'hD, 3'd1, 3'd0, 6'd1);
    m_imem[1] = enc_i(4'hD, 3'd2, 3'd0, 6'd2);
    m_imem[2] = enc_i(4'hD, 3'd3, 3'd0, 6'd3);
    load_imem(); go();
    step(2);
    ld_sel = 1'b0; ld_addr = 4'd2; ld_wdata = enc_i(4'hD, 3'd3, 3'd0, 6'd7);
    ld_we = 1'b1; start = 1'b1;
    step(1);
    ld_we = 1'b0; start = 1'b0;
    wait_halt(cyc);
    n_checks++; if (cyc + 3 !== 15) begin n_fail++; $display("FAIL busy_start_cycles: got %0d expected 15", cyc + 3); end
    rd_reg(3'd3, v);
    n_checks++; if (v !== 16'd3) begin n_fail++; $display("FAIL busy_ld_imem: got %h expected 0003", v); end
  endtask

  task automatic test_reset_mid_sw();
    int cyc;
    logic [15:0] v;
    do_reset(); clear_prog();
    load_word(1'b1, 4'd3, 16'h0055);
    m_imem[0] = enc_i(4'hD, 3'd5, 3'd0, 6'd9);
    m_imem[1] = enc_i(4'h8, 3'd5, 3'd0, 6'd3);
    load_imem(); go();
    step(7);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midsw_busy: got %b expected 1", busy); end
    reset = 1'b0; #2;
    n_checks++; if (busy !== 1'b0 || halted !== 1'b0 || pc !== 4'd0) begin n_fail++; $display("FAIL midsw_state: got busy=%b halted=%b pc=%0d expected 0/0/0", busy, halted, pc); end
    rd_reg(3'd5, v);
    n_checks++; if (v !== 16'd0) begin n_fail++; $display("FAIL midsw_R5: got %h expected 0000", v); end
    @(posedge clk); #1;
    reset = 1'b1;
    clear_prog();
    m_imem[0] = enc_i(4'h7, 3'd6, 3'd0, 6'd3);
    load_imem(); go(); wait_halt(cyc);
    rd_reg(3'd6, v);
    n_checks++; if (v !== 16'h0055) begin n_fail++; $display("FAIL midsw_dmem: got %h expected 0055", v); end
  endtask

  task automatic test_random();
    int cyc, exp_cyc, n;
    logic [3:0] exp_pc;
    logic [15:0] v;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) m_dmem[i] = 16'($urandom);
      load_dmem();
      clear_prog();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) m_imem[i] = {ops[$urandom_range(0, 12)], 12'($urandom)};
      load_imem();
      model_run(exp_cyc, exp_pc);
      go(); wait_halt(cyc);
      n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL rand%0d_cycles: got %0d expected %0d", it, cyc, exp_cyc); end
      n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rand%0d_pc: got %0d expected %0d", it, pc, exp_pc); end
      for (int r = 0; r < 8; r++) begin
        rd_reg(3'(r), v);
        n_checks++; if (v !== m_reg[r]) begin n_fail++; $display("FAIL rand%0d_R%0d: got %h expected %h", it, r, v, m_reg[r]); end
      end
    end
  endtask

`ifdef DATAPATH_TRACE_EN
  task automatic test_trace();
    logic [3:0] exp_pcs [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
    logic [3:0] seen [$];
    int cyc;
    do_reset(); clear_prog();
    m_imem[0] = enc_i(4'hD, 3'd1, 3'd0, 6'd3);
    m_imem[1] = enc_i(4'h8, 3'd1, 3'd0, 6'd1);
    m_imem[2] = enc_i(4'h7, 3'd2, 3'd0, 6'd1);
    m_imem[3] = enc_i(4'hE, 3'd2, 3'd1, 6'd5);
    load_imem(); go();
    cyc = 0;
    while (halted !== 1'b1 && cyc < 400) begin
      if (retire_valid === 1'b1) seen.push_back(retire_pc);
      step(1); cyc++;
    end
    if (retire_valid === 1'b1) seen.push_back(retire_pc);
    n_checks++; if (seen.size() !== 5) begin n_fail++; $display("FAIL trace_count: got %0d expected 5", seen.size()); end
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      n_checks++; if (seen[i] !== exp_pcs[i]) begin n_fail++; $display("FAIL trace_pc%0d: got %0d expected %0d", i, seen[i], exp_pcs[i]); end
    end
  endtask
`endif

  initial begin
    reset = 1'b0; start = 1'b0; ld_we = 1'b0; ld_sel = 1'b0;
    ld_addr = 4'd0; ld_wdata = 16'd0; dbg_raddr = 3'd0;
    test_reset();
    test_alu_program();
    test_memory();
    test_branch();
    test_r0_wrap();
    test_start_with_load();
    test_busy_ignores();
    test_reset_mid_sw();
    test_random();
`ifdef DATAPATH_TRACE_EN
    test_trace();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
